logs_seq: RTL and testbench

LOGS_SEQ -- requirements
Module: logs_seq

---
 rtl/logs_pkg.sv | 24 ++
 rtl/logs_seq_table.sv | 37 +++
 rtl/logs_seq.sv | 188 ++++++++++++++++++
 tb/tb_logs_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logs_pkg.sv
// Shared definitions for the pattern sequencer: FSM encoding, field widths
// and small helpers used by the controller.
package logs_pkg;

  localparam int unsigned ST_W   = 3;
  localparam int unsigned DUR_W  = 4;
  localparam int unsigned BEAT_W = 8;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_PLAY = 3'd2;
  localparam logic [ST_W-1:0] ST_GAP  = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE = 3'd4;

  // A beat divider of zero behaves as one step pulse per beat.
  function automatic logic [BEAT_W-1:0] beat_div_eff(input logic [BEAT_W-1:0] div);
    return (div == '0) ? BEAT_W'(1) : div;
  endfunction

  function automatic logic is_busy_state(input logic [ST_W-1:0] st);
    return (st == ST_LOAD) || (st == ST_PLAY) || (st == ST_GAP);
  endfunction

endpackage

// File: rtl/logs_seq_table.sv
// Pattern table: DEPTH-entry register file, one write port and one
// registered read port that returns the pre-write contents on a collision.
module logs_seq_table #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;

  // Storage and read register share one process so reset clears both together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/logs_seq.sv
// Pattern sequencer: steps through a table of (frequency, duration) notes and
// drives one external NCO, using step_in as its time base.
module logs_seq
  import logs_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     step_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-2:0]             wr_freq,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic [BEAT_W-1:0]        beat_div,
  output logic [N-2:0]             nco_freq,
  output logic                     nco_step,
  output logic                     nco_reset,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = N - 1;
  localparam int unsigned EW = FW + DUR_W;
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_state_nxt;
  logic [AW-1:0]     r_idx;
  logic [AW-1:0]     w_idx_nxt;
  logic [FW-1:0]     r_freq;
  logic [FW-1:0]     w_freq_nxt;
  logic [DUR_W-1:0]  r_dur_cnt;
  logic [DUR_W-1:0]  w_dur_cnt_nxt;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [BEAT_W-1:0] w_beat_cnt_nxt;
  logic              r_busy;
  logic              r_nco_reset;
  logic              r_step_en;
  logic              r_done;

  logic [EW-1:0]     w_wr_data;
  logic [EW-1:0]     w_rd_data;
  logic [FW-1:0]     w_ent_freq;
  logic [DUR_W-1:0]  w_ent_dur;
  logic [BEAT_W-1:0] w_div;
  logic [BEAT_W-1:0] w_beat_inc;
  logic              w_tone_nxt;

  assign w_wr_data  = {wr_freq, wr_dur};
  assign w_ent_freq = w_rd_data[EW-1:DUR_W];
  assign w_ent_dur  = w_rd_data[DUR_W-1:0];
  assign w_div      = beat_div_eff(beat_div);
  assign w_beat_inc = r_beat_cnt + BEAT_W'(1);

  // The read address is the next index, so the entry is ready during LOAD.
  logs_seq_table #(
    .DEPTH (DEPTH),
    .DW    (EW),
    .AW    (AW)
  ) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (w_wr_data),
    .i_rd_addr (w_idx_nxt),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_freq      <= '0;
      r_dur_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_busy      <= 1'b0;
      r_nco_reset <= 1'b1;
      r_step_en   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_freq      <= w_freq_nxt;
      r_dur_cnt   <= w_dur_cnt_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_busy      <= is_busy_state(w_state_nxt);
      r_nco_reset <= !w_tone_nxt;
      r_step_en   <= w_tone_nxt;
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state and next-register values; stop overrides every state.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_freq_nxt     = r_freq;
    w_dur_cnt_nxt  = r_dur_cnt;
    w_beat_cnt_nxt = r_beat_cnt;

    if (stop) begin
      w_state_nxt    = ST_IDLE;
      w_idx_nxt      = '0;
      w_dur_cnt_nxt  = '0;
      w_beat_cnt_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
          end
        end
        ST_LOAD: begin
          if (w_ent_dur == '0) begin
            if (loop && (r_idx != '0)) begin
              w_state_nxt = ST_LOAD;
              w_idx_nxt   = '0;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end else begin
            w_freq_nxt     = w_ent_freq;
            w_dur_cnt_nxt  = w_ent_dur;
            w_beat_cnt_nxt = '0;
            w_state_nxt    = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (step_in) begin
            if (w_beat_inc == w_div) begin
              w_beat_cnt_nxt = '0;
              w_dur_cnt_nxt  = r_dur_cnt - DUR_W'(1);
              if (r_dur_cnt == DUR_W'(1)) begin
                w_state_nxt = ST_GAP;
              end
            end else begin
              w_beat_cnt_nxt = w_beat_inc;
            end
          end
        end
        ST_GAP: begin
          // Articulation gap ends on the next step pulse.
          if (step_in) begin
            if (r_idx != IDX_LAST) begin
              w_idx_nxt   = r_idx + AW'(1);
              w_state_nxt = ST_LOAD;
            end else if (loop) begin
              w_idx_nxt   = '0;
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    if (!is_busy_state(w_state_nxt)) begin
      w_freq_nxt = '0;
    end
  end

  // A zero frequency in PLAY is a rest: the NCO stays held in reset.
  assign w_tone_nxt = (w_state_nxt == ST_PLAY) && (w_freq_nxt != '0);

  assign nco_freq  = r_freq;
  assign nco_step  = step_in & r_step_en;
  assign nco_reset = r_nco_reset;
  assign busy      = r_busy;
  assign idx       = r_idx;
  assign done      = r_done;

endmodule

// File: tb/tb_logs_seq.sv
// Randomized scoreboard bench for logs_seq: a note-level reference model
// predicts audible notes and completion; a monitor checks what the DUT plays.
module tb_logs_seq;

  localparam int unsigned N     = 5;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned FW    = N - 1;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          step_in  = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [FW-1:0] wr_freq  = '0;
  logic [3:0]    wr_dur   = '0;
  logic          start    = 1'b0;
  logic          stop     = 1'b0;
  logic          loop     = 1'b0;
  logic [7:0]    beat_div = 8'd1;
  logic [FW-1:0] nco_freq;
  logic          nco_step;
  logic          nco_reset;
  logic          busy;
  logic [AW-1:0] idx;
  logic          done;

  logs_seq #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_in   (step_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_freq   (wr_freq),
    .wr_dur    (wr_dur),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .beat_div  (beat_div),
    .nco_freq  (nco_freq),
    .nco_step  (nco_step),
    .nco_reset (nco_reset),
    .busy      (busy),
    .idx       (idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  // kind 0 = audible note, kind 1 = done pulse; -1 in a field means "don't care"
  typedef struct {
    int kind;
    int idx;
    int freq;
    int pulses;
    int busy;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   step_prob = 100;
  int   tf[DEPTH];
  int   td[DEPTH];

  bit   m_in_run    = 1'b0;
  bit   m_prev_done = 1'b0;
  int   m_idx       = 0;
  int   m_freq      = 0;
  int   m_pulses    = 0;
  int   m_bcnt      = 0;
  exp_t m_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int f, input int d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_freq = FW'(f);
    wr_dur  = 4'(d);
    tick();
    wr_en = 1'b0;
    tf[a] = f;
    td[a] = d;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < DEPTH; i++) wr(i, 0, 0);
  endtask

  task automatic push_note(input int i, input int f, input int p);
    exp_t e;
    e.kind = 0; e.idx = i; e.freq = f; e.pulses = p; e.busy = -1;
    q.push_back(e);
  endtask

  task automatic push_done(input int b);
    exp_t e;
    e.kind = 1; e.idx = -1; e.freq = -1; e.pulses = -1; e.busy = b;
    q.push_back(e);
  endtask

  // Note-level reference: walk the pattern, taking nwraps loop wraps.
  // Busy cycles assume a step pulse every cycle: each note costs
  // load + dur*beats + gap, each end-of-pattern marker costs one load.
  task automatic model(input int nwraps, input bit busy_known);
    int i;
    int w;
    int bc;
    int dd;
    i  = 0;
    w  = nwraps;
    bc = 0;
    dd = (beat_div == 8'd0) ? 1 : int'(beat_div);
    while (1) begin
      if (td[i] == 0) begin
        bc++;
        if (w > 0 && i != 0) begin
          w--;
          i = 0;
        end else break;
      end else begin
        if (tf[i] != 0) push_note(i, tf[i], dd * td[i]);
        bc += dd * td[i] + 2;
        if (i == DEPTH - 1) begin
          if (w > 0) begin
            w--;
            i = 0;
          end else break;
        end else i++;
      end
    end
    push_done(busy_known ? bc : -1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (3) tick();
  endtask

  task automatic wait_idx(input int v);
    int n;
    n = 0;
    while (int'(idx) != v && n < 200) begin
      tick();
      n++;
    end
    chk("wait_idx", int'(idx), v);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_nco_reset"}, int'(nco_reset), 1);
    chk({tag, "_nco_step"},  int'(nco_step), 0);
    chk({tag, "_nco_freq"},  int'(nco_freq), 0);
    chk({tag, "_done"},      int'(done), 0);
  endtask

  initial begin : step_drv
    forever begin
      @(posedge clk);
      #1;
      step_in = (int'($urandom_range(0, 99)) < step_prob);
    end
  end

  // Monitor: closes a tone run when the NCO is put back in reset.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (nco_reset) chk("rest_step_low", int'(nco_step), 0);
      if (!busy) begin
        chk("idle_nco_reset", int'(nco_reset), 1);
        chk("idle_nco_freq", int'(nco_freq), 0);
      end
      if (m_in_run && (nco_reset || !busy)) begin
        m_in_run = 1'b0;
        chk("pending_expect_note", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          m_e = q.pop_front();
          chk("event_kind_note", 0, m_e.kind);
          chk("note_idx", m_idx, m_e.idx);
          chk("note_freq", m_freq, m_e.freq);
          if (m_e.pulses >= 0) chk("note_pulses", m_pulses, m_e.pulses);
        end
      end
      if (!nco_reset && busy) begin
        if (!m_in_run) begin
          m_in_run = 1'b1;
          m_idx    = int'(idx);
          m_freq   = int'(nco_freq);
          m_pulses = 0;
        end
        chk("note_freq_stable", int'(nco_freq), m_freq);
        if (nco_step) m_pulses++;
      end
      if (done) begin
        chk("done_width", int'(m_prev_done), 0);
        chk("done_busy_low", int'(busy), 0);
        chk("pending_expect_done", int'(q.size() > 0), 1);
        if (q.size() > 0) begin
          m_e = q.pop_front();
          chk("event_kind_done", 1, m_e.kind);
          if (m_e.busy >= 0) chk("busy_cycles", m_bcnt, m_e.busy);
        end
      end
      if (busy) m_bcnt++;
      else if (!done) m_bcnt = 0;
      m_prev_done = done;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d;
    for (int i = 0; i < DEPTH; i++) begin
      tf[i] = 0;
      td[i] = 0;
    end
    #1 rst_n = 1'b0;
    #11;
    chk_reset_outputs("por");
    chk("por_idx", int'(idx), 0);
    #11 rst_n = 1'b1;
    repeat (2) tick();

    // Single note (5,1), beat_div=2: two step pulses, then gap, done
    clear_tbl();
    wr(0, 5, 1);
    beat_div = 8'd2;
    loop = 1'b0;
    model(0, 1'b1);
    pulse_start();
    drain(200);
    chk("idle_after_done", int'(busy), 0);

    // Rest entry (0,2): NCO stays in reset for 4 beat pulses
    clear_tbl();
    wr(0, 0, 2);
    beat_div = 8'd2;
    model(0, 1'b1);
    pulse_start();
    drain(200);

    // beat_div=0 behaves as 1: dur=3 lasts 3 step pulses
    clear_tbl();
    wr(0, 9, 3);
    beat_div = 8'd0;
    model(0, 1'b1);
    pulse_start();
    drain(200);

    // Full table with loop: one wrap 7->0, then loop dropped
    for (int i = 0; i < DEPTH; i++) wr(i, i + 1, 1);
    beat_div = 8'd1;
    loop = 1'b1;
    model(1, 1'b1);
    pulse_start();
    wait_idx(7);
    wait_idx(0);
    wait_idx(4);
    loop = 1'b0;
    drain(500);

    // Stop with start in the same cycle during PLAY
    clear_tbl();
    wr(0, 9, 15);
    beat_div = 8'd4;
    push_note(0, 9, -1);
    pulse_start();
    repeat (10) tick();
    stop  = 1'b1;
    start = 1'b1;
    tick();
    stop  = 1'b0;
    start = 1'b0;
    chk_reset_outputs("stop");
    repeat (5) tick();
    chk("stop_stays_idle", int'(busy), 0);
    chk("stop_queue_empty", q.size(), 0);

    // Asynchronous reset during PLAY clears outputs and the table
    clear_tbl();
    wr(0, 7, 15);
    beat_div = 8'd4;
    push_note(0, 7, -1);
    pulse_start();
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    chk("arst_idx", int'(idx), 0);
    for (int i = 0; i < DEPTH; i++) begin
      tf[i] = 0;
      td[i] = 0;
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    beat_div = 8'd1;
    model(0, 1'b1);
    pulse_start();
    drain(200);

    // Randomized patterns, rests and end markers, varied step density
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
        wr(i, int'($urandom_range(0, 15)), d);
      end
      beat_div  = 8'($urandom_range(0, 3));
      step_prob = (it % 2 == 1) ? 60 : 100;
      loop      = 1'b0;
      model(0, step_prob == 100);
      pulse_start();
      drain(3000);
    end
    step_prob = 100;

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
